// File: rtl/dense_mac_sequencer_pkg.sv
// Shared definitions for the dense-layer MAC sequencer and the fixed-point
// MAC/saturate datapath it shares with the conv stage.
//   state_t           : sequencer FSM encoding (IDLE=0, RUN=1, OUT=2)
//   DEF_FRAC_BITS     : default fractional bits of the shared Q format
//   SAT_MAX/MIN_W32   : clip bounds for the default 32-bit word
package dense_mac_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_OUT  = 2'd2
  } state_t;

  localparam int DEF_FRAC_BITS = 16;
  localparam int DEF_WORD_SIZE = 32;

  localparam logic [DEF_WORD_SIZE-1:0] SAT_MAX_W32 = 32'h7FFF_FFFF;
  localparam logic [DEF_WORD_SIZE-1:0] SAT_MIN_W32 = 32'h8000_0000;

endpackage

// File: rtl/dense_mac_sequencer_fxp_mac_sat.sv
// fxp_mac_sat: combinational signed fixed-point multiply-accumulate plus an
// output clip from the accumulator width down to the word width.
//   acc_in   : current accumulator (ACC_SIZE, signed)
//   feat     : feature operand (WORD_SIZE, signed, Q(FRAC_BITS))
//   weight   : weight operand  (WORD_SIZE, signed, Q(FRAC_BITS))
//   acc_sum  : acc_in + ((feat * weight) >>> FRAC_BITS), wrapped to ACC_SIZE
//   sat_data : acc_sum clipped to the WORD_SIZE signed range
//   sat_flag : high when the clip changed the value
module fxp_mac_sat
  import dense_mac_sequencer_pkg::*;
#(
  parameter int WORD_SIZE = 32,
  parameter int ACC_SIZE  = 40,
  parameter int FRAC_BITS = DEF_FRAC_BITS
) (
  input  logic [ACC_SIZE-1:0]  acc_in,
  input  logic [WORD_SIZE-1:0] feat,
  input  logic [WORD_SIZE-1:0] weight,
  output logic [ACC_SIZE-1:0]  acc_sum,
  output logic [WORD_SIZE-1:0] sat_data,
  output logic                 sat_flag
);

  localparam int PROD_W = 2 * WORD_SIZE;
  // Working width wide enough for both the full product and the accumulator,
  // so sign extension happens before the shift and truncation after it.
  localparam int EXT_W  = (ACC_SIZE > PROD_W) ? ACC_SIZE : PROD_W;

  // Word-range bounds expressed at accumulator width for signed compares.
  localparam logic signed [ACC_SIZE-1:0] ACC_MAX =
    {{(ACC_SIZE-WORD_SIZE+1){1'b0}}, {(WORD_SIZE-1){1'b1}}};
  localparam logic signed [ACC_SIZE-1:0] ACC_MIN =
    {{(ACC_SIZE-WORD_SIZE+1){1'b1}}, {(WORD_SIZE-1){1'b0}}};

  logic signed [PROD_W-1:0] feat_ext;
  logic signed [PROD_W-1:0] weight_ext;
  logic signed [PROD_W-1:0] prod;
  logic signed [EXT_W-1:0]  prod_wide;
  logic signed [EXT_W-1:0]  prod_shr;
  logic        [ACC_SIZE-1:0] term;

  assign feat_ext   = PROD_W'($signed(feat));
  assign weight_ext = PROD_W'($signed(weight));
  assign prod       = feat_ext * weight_ext;
  assign prod_wide  = EXT_W'(prod);
  // Arithmetic shift: truncation toward -inf.
  assign prod_shr   = prod_wide >>> FRAC_BITS;
  assign term       = ACC_SIZE'(prod_shr);
  assign acc_sum    = acc_in + term;

  // Returns {clipped_flag, clipped_word}.
  function automatic logic [WORD_SIZE:0] saturate(input logic signed [ACC_SIZE-1:0] v);
    if (v > ACC_MAX)
      return {1'b1, ACC_MAX[WORD_SIZE-1:0]};
    else if (v < ACC_MIN)
      return {1'b1, ACC_MIN[WORD_SIZE-1:0]};
    else
      return {1'b0, WORD_SIZE'(v)};
  endfunction

  assign {sat_flag, sat_data} = saturate($signed(acc_sum));

endmodule

// File: rtl/dense_mac_sequencer.sv
// dense_mac_sequencer: evaluates one dense-layer neuron. Steps the weight LUT
// address 0..LENGTH_SIZE-1, consumes one feature per address, accumulates
// bias + sum(feature*weight) in fixed point and presents the clipped result.
//   start/bias_in            : begin a neuron (IDLE only), bias latched then
//   busy                     : high in RUN and OUT
//   weight_adr/weight_data   : combinational LUT read, same cycle
//   feat_data/valid/ready    : upstream feature stream
//   out_data/valid/ready     : downstream result stream, sat flags clipping
//   done                     : one-cycle pulse on the result handshake
// Handshakes: a transfer happens in every cycle where valid && ready are both
// high at the rising edge; valid never depends on ready, data is held while
// valid is high and ready is low.
module dense_mac_sequencer
  import dense_mac_sequencer_pkg::*;
#(
  parameter int WORD_SIZE   = 32,
  parameter int LENGTH_SIZE = 10,
  parameter int ADR_SIZE    = 4,
  parameter int FRAC_BITS   = DEF_FRAC_BITS,
  parameter int ACC_SIZE    = 40
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WORD_SIZE-1:0] bias_in,
  output logic                 busy,
  output logic [ADR_SIZE-1:0]  weight_adr,
  input  logic [WORD_SIZE-1:0] weight_data,
  input  logic [WORD_SIZE-1:0] feat_data,
  input  logic                 feat_valid,
  output logic                 feat_ready,
  output logic [WORD_SIZE-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 sat,
  output logic                 done
);

  localparam logic [ADR_SIZE-1:0] LAST_IDX = ADR_SIZE'(LENGTH_SIZE - 1);

  state_t               state;
  logic [ADR_SIZE-1:0]  idx;
  logic [ACC_SIZE-1:0]  acc;
  logic [WORD_SIZE-1:0] out_q;
  logic                 sat_q;

  logic [ACC_SIZE-1:0]  acc_sum;
  logic [WORD_SIZE-1:0] sat_data;
  logic                 sat_flag;

  fxp_mac_sat #(
    .WORD_SIZE (WORD_SIZE),
    .ACC_SIZE  (ACC_SIZE),
    .FRAC_BITS (FRAC_BITS)
  ) u_mac (
    .acc_in   (acc),
    .feat     (feat_data),
    .weight   (weight_data),
    .acc_sum  (acc_sum),
    .sat_data (sat_data),
    .sat_flag (sat_flag)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      idx   <= '0;
      acc   <= '0;
      out_q <= '0;
      sat_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            acc   <= {{(ACC_SIZE-WORD_SIZE){bias_in[WORD_SIZE-1]}}, bias_in};
            idx   <= '0;
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (feat_valid) begin
            acc <= acc_sum;
            if (idx == LAST_IDX) begin
              // Result is clipped from the final sum and frozen for OUT.
              out_q <= sat_data;
              sat_q <= sat_flag;
              state <= ST_OUT;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        ST_OUT: begin
          if (out_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy       = (state == ST_RUN) || (state == ST_OUT);
  assign weight_adr = idx;
  assign feat_ready = (state == ST_RUN);
  assign out_valid  = (state == ST_OUT);
  assign out_data   = out_q;
  assign sat        = sat_q;
  assign done       = (state == ST_OUT) && out_ready;

endmodule

// File: tb/tb_dense_mac_sequencer.sv
module tb_dense_mac_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] bias_in;
  logic        busy;
  logic [3:0]  weight_adr;
  logic [31:0] weight_data;
  logic [31:0] feat_data;
  logic        feat_valid;
  logic        feat_ready;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        sat;
  logic        done;

  int n_cmp = 0;
  int n_err = 0;

  // LUT stub and feature buffer stub
  logic [31:0] lut [16];
  logic [31:0] feat_mem [16];
  logic [3:0]  feat_ptr;
  logic        ptr_clr;

  // Results captured by run_neuron
  int          r_lat, r_done_cnt, r_done_n;
  bit          r_stall_ok;
  logic [31:0] r_data;
  logic        r_sat;
  logic        r_out_after, r_busy_after;
  logic [31:0] r_data_after;
  logic [3:0]  adr_log[$];

  always #5 clk = ~clk;

  assign weight_data = lut[weight_adr];
  assign feat_data   = feat_mem[feat_ptr];

  always @(posedge clk) begin
    if (ptr_clr) feat_ptr <= 4'd0;
    else if (feat_valid && feat_ready) feat_ptr <= feat_ptr + 4'd1;
  end

  dense_mac_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .bias_in     (bias_in),
    .busy        (busy),
    .weight_adr  (weight_adr),
    .weight_data (weight_data),
    .feat_data   (feat_data),
    .feat_valid  (feat_valid),
    .feat_ready  (feat_ready),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .sat         (sat),
    .done        (done)
  );

  task automatic fill_feat(input logic [31:0] v);
    for (int i = 0; i < 16; i++) feat_mem[i] = v;
  endtask

  // Drives one neuron evaluation and records what was observed.
  task automatic run_neuron(input logic [31:0] b, input bit toggle, input int stall, input bit poke);
    int out_cnt;
    bit seen;
    logic [31:0] first_d;
    logic first_s;
    out_cnt = 0; seen = 0; first_d = '0; first_s = 1'b0;
    r_lat = -1; r_done_cnt = 0; r_done_n = -1; r_stall_ok = 1;
    r_data = 'x; r_sat = 1'bx;
    adr_log.delete();
    @(posedge clk); #1;
    start = 1'b1; bias_in = b; ptr_clr = 1'b1; feat_valid = 1'b0; out_ready = 1'b0;
    for (int n = 1; n <= 200; n++) begin
      @(posedge clk); #1;
      start = poke; ptr_clr = 1'b0;
      feat_valid = toggle ? n[0] : 1'b1;
      if (out_valid) begin
        out_ready = (out_cnt >= stall);
        out_cnt++;
      end else begin
        out_ready = 1'b0;
      end
      @(negedge clk);
      if (feat_valid && feat_ready) adr_log.push_back(weight_adr);
      if (out_valid) begin
        if (!seen) begin
          seen = 1; r_lat = n; first_d = out_data; first_s = sat;
        end else if (out_data !== first_d || sat !== first_s) begin
          r_stall_ok = 0;
        end
      end
      if (done) begin
        r_done_cnt++; r_done_n = n; r_data = out_data; r_sat = sat;
        break;
      end
    end
    @(posedge clk); #1;
    start = 1'b0; out_ready = 1'b0; feat_valid = 1'b0;
    @(negedge clk);
    if (done) r_done_cnt++;
    r_out_after = out_valid; r_busy_after = busy; r_data_after = out_data;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; bias_in = '0; feat_valid = 1'b0; out_ready = 1'b0; ptr_clr = 1'b1;
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (weight_adr !== 4'd0) begin n_err++; $display("FAIL reset_adr: got %h want 0", weight_adr); end
    n_cmp++; if (feat_ready !== 1'b0 || out_valid !== 1'b0 || done !== 1'b0) begin
      n_err++; $display("FAIL reset_hs: got fr=%b ov=%b dn=%b want 0 0 0", feat_ready, out_valid, done); end
    n_cmp++; if (out_data !== 32'h0 || sat !== 1'b0) begin
      n_err++; $display("FAIL reset_out: got %h/%b want 00000000/0", out_data, sat); end
    @(posedge clk); #1 rst = 1'b0; ptr_clr = 1'b0;
  endtask

  task automatic test_basic;
    bit seq_ok;
    fill_feat(32'h0001_0000);
    run_neuron(32'h0, 1'b0, 0, 1'b0);
    n_cmp++; if (r_data !== 32'h0037_0000) begin n_err++; $display("FAIL basic_data: got %h want 00370000", r_data); end
    n_cmp++; if (r_sat !== 1'b0) begin n_err++; $display("FAIL basic_sat: got %b want 0", r_sat); end
    n_cmp++; if (r_lat != 11) begin n_err++; $display("FAIL basic_latency: got %0d want 11", r_lat); end
    n_cmp++; if (r_done_n != 11 || r_done_cnt != 1) begin
      n_err++; $display("FAIL basic_done: got cycle %0d count %0d want 11/1", r_done_n, r_done_cnt); end
    seq_ok = (adr_log.size() == 10);
    for (int i = 0; i < adr_log.size(); i++) if (adr_log[i] !== 4'(i)) seq_ok = 0;
    n_cmp++; if (!seq_ok) begin n_err++; $display("FAIL basic_adr_seq: got %0d entries (first bad order) want 0..9", adr_log.size()); end
    n_cmp++; if (r_out_after !== 1'b0 || r_busy_after !== 1'b0) begin
      n_err++; $display("FAIL basic_after: got ov=%b busy=%b want 0 0", r_out_after, r_busy_after); end
  endtask

  task automatic test_single_feature;
    fill_feat(32'h0);
    feat_mem[3] = 32'h0002_0000;
    run_neuron(32'hFFFF_0000, 1'b0, 0, 1'b0);
    n_cmp++; if (r_data !== 32'h0007_0000) begin n_err++; $display("FAIL single_data: got %h want 00070000", r_data); end
    n_cmp++; if (r_sat !== 1'b0) begin n_err++; $display("FAIL single_sat: got %b want 0", r_sat); end
  endtask

  task automatic test_stall;
    bit seq_ok;
    fill_feat(32'h0001_0000);
    run_neuron(32'h0, 1'b1, 5, 1'b1);
    n_cmp++; if (r_data !== 32'h0037_0000) begin n_err++; $display("FAIL stall_data: got %h want 00370000", r_data); end
    n_cmp++; if (!r_stall_ok) begin n_err++; $display("FAIL stall_stable: got changing out_data/sat want stable"); end
    n_cmp++; if (r_done_cnt != 1) begin n_err++; $display("FAIL stall_done_count: got %0d want 1", r_done_cnt); end
    n_cmp++; if (r_done_n != r_lat + 5) begin n_err++; $display("FAIL stall_done_cycle: got %0d want %0d", r_done_n, r_lat + 5); end
    seq_ok = (adr_log.size() == 10);
    for (int i = 0; i < adr_log.size(); i++) if (adr_log[i] !== 4'(i)) seq_ok = 0;
    n_cmp++; if (!seq_ok) begin n_err++; $display("FAIL stall_adr_seq: got %0d entries want 0..9", adr_log.size()); end
    n_cmp++; if (r_busy_after !== 1'b0 || r_out_after !== 1'b0) begin
      n_err++; $display("FAIL stall_start_ignored: got busy=%b ov=%b want 0 0", r_busy_after, r_out_after); end
    n_cmp++; if (r_data_after !== 32'h0037_0000) begin n_err++; $display("FAIL stall_retain: got %h want 00370000", r_data_after); end
  endtask

  task automatic test_sat_pos;
    fill_feat(32'h0001_0000);
    run_neuron(32'h7FFF_0000, 1'b0, 0, 1'b0);
    n_cmp++; if (r_data !== 32'h7FFF_FFFF) begin n_err++; $display("FAIL satpos_data: got %h want 7fffffff", r_data); end
    n_cmp++; if (r_sat !== 1'b1) begin n_err++; $display("FAIL satpos_flag: got %b want 1", r_sat); end
  endtask

  task automatic test_sat_neg;
    fill_feat(32'hFFFF_0000);
    run_neuron(32'h8001_0000, 1'b0, 0, 1'b0);
    n_cmp++; if (r_data !== 32'h8000_0000) begin n_err++; $display("FAIL satneg_data: got %h want 80000000", r_data); end
    n_cmp++; if (r_sat !== 1'b1) begin n_err++; $display("FAIL satneg_flag: got %b want 1", r_sat); end
  endtask

  task automatic test_reset_mid_run;
    bit hit;
    hit = 0;
    fill_feat(32'h0001_0000);
    @(posedge clk); #1;
    start = 1'b1; bias_in = 32'h0; ptr_clr = 1'b1; feat_valid = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; ptr_clr = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (busy && weight_adr == 4'd4) begin hit = 1; break; end
    end
    n_cmp++; if (!hit) begin n_err++; $display("FAIL midrun_reach_idx4: got no idx 4 within 20 cycles want idx 4"); end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (busy !== 1'b0 || feat_ready !== 1'b0 || out_valid !== 1'b0 || done !== 1'b0) begin
      n_err++; $display("FAIL midrun_async_ctl: got busy=%b fr=%b ov=%b dn=%b want 0 0 0 0", busy, feat_ready, out_valid, done); end
    n_cmp++; if (weight_adr !== 4'd0) begin n_err++; $display("FAIL midrun_async_adr: got %h want 0", weight_adr); end
    n_cmp++; if (out_data !== 32'h0 || sat !== 1'b0) begin
      n_err++; $display("FAIL midrun_async_out: got %h/%b want 00000000/0", out_data, sat); end
    feat_valid = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    run_neuron(32'h0, 1'b0, 0, 1'b0);
    n_cmp++; if (r_data !== 32'h0037_0000 || r_sat !== 1'b0) begin
      n_err++; $display("FAIL midrun_rerun: got %h/%b want 00370000/0", r_data, r_sat); end
    n_cmp++; if (r_lat != 11) begin n_err++; $display("FAIL midrun_rerun_latency: got %0d want 11", r_lat); end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) lut[i] = (i < 10) ? (32'(i + 1) << 16) : 32'h0;
    fill_feat(32'h0);
    test_reset;
    test_basic;
    test_single_feature;
    test_stall;
    test_sat_pos;
    test_sat_neg;
    test_reset_mid_run;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no end of test within 200000 time units want completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/dense_mac_sequencer.md
Name: dense_mac_sequencer

Overview:
- Sequences one dense-layer neuron: steps the weight LUT address 0..LENGTH_SIZE-1 and consumes one input feature per address over a valid/ready stream.
- Multiply-accumulates in signed fixed point, adds a bias, saturates, and presents the neuron result on a valid/ready output.
- Sits between the feature buffer (upstream) and the dense weight LUT (combinational read, same cycle); the classifier / argmax stage is downstream.

Parameters:
- WORD_SIZE, 32, width of weights, features, bias and result; signed two's complement.
- LENGTH_SIZE, 10, number of weights/features per neuron; must be >= 1.
- ADR_SIZE, 4, LUT address width; ceil(log2(LENGTH_SIZE)) <= ADR_SIZE.
- FRAC_BITS, 16, fractional bits of the shared Q format.
- ACC_SIZE, 40, accumulator width; must be > WORD_SIZE.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous reset, active-high
- start  in  1  begin one neuron evaluation; sampled in IDLE only
- bias_in  in  WORD_SIZE  bias; latched on the accepted start
- busy  out  1  high in RUN and OUT
- weight_adr  out  ADR_SIZE  LUT address
- weight_data  in  WORD_SIZE  LUT data, valid combinationally in the same cycle
- feat_data  in  WORD_SIZE  input feature
- feat_valid  in  1  feature present
- feat_ready  out  1  feature accepted when feat_valid && feat_ready
- out_data  out  WORD_SIZE  saturated result
- out_valid  out  1  result present
- out_ready  in  1  downstream accepts the result
- sat  out  1  result was clipped; valid while out_valid
- done  out  1  one-cycle pulse on result handshake

Behaviour:
- Reset (async, any state): state=IDLE, idx=0, acc=0; all outputs 0, including weight_adr, out_data and sat.
- IDLE: feat_ready=0, out_valid=0. On start: acc <= sign-extend(bias_in) to ACC_SIZE, idx <= 0, go to RUN.
- RUN: weight_adr=idx, feat_ready=1.
  - On a feature handshake: acc <= acc + ((feat_data * weight_data) >>> FRAC_BITS).
  - The product is full 2*WORD_SIZE signed with an arithmetic shift (truncation toward -inf), then sign-extended or truncated to ACC_SIZE.
  - If idx==LENGTH_SIZE-1, go to OUT; else idx <= idx+1.
  - With no handshake, hold all state; stalls are unbounded.
- OUT: out_valid=1, feat_ready=0.
  - out_data = acc clipped to [-2^(WORD_SIZE-1), 2^(WORD_SIZE-1)-1]; sat=1 if clipped.
  - out_data and sat are registered on entry to OUT and held stable while out_ready=0.
  - On out_ready: done=1 for that cycle, go to IDLE. out_data is retained, out_valid drops.
- Latency with continuous feat_valid and out_ready=1:
  - start accepted in cycle 0; RUN covers cycles 1..LENGTH_SIZE.
  - out_valid is high in cycle LENGTH_SIZE+1, with done in the same cycle.
- start outside IDLE is ignored. start in the same cycle as the OUT handshake is ignored; the next start is accepted in IDLE.
- weight_adr never exceeds LENGTH_SIZE-1. idx does not wrap inside a run.
- Intermediate accumulator overflow beyond ACC_SIZE is not detected; ACC_SIZE is sized by the integrator. Saturation applies only at output.

Decomposition:
- Shared package: state encoding (IDLE=0, RUN=1, OUT=2), FRAC_BITS default, saturation min/max constants per WORD_SIZE.
- One sub-module: fxp_mac_sat.
  - Combinational signed multiply, arithmetic shift and accumulate-add.
  - Separate saturate function for the ACC_SIZE to WORD_SIZE clip.
  - Reused by the conv stage.
- The FSM, index counter and handshakes stay in dense_mac_sequencer.

Test Plan:
- The bench uses a LUT stub with mem[i]=(i+1)<<16 (1.0..10.0); bias 0 and all features 0x00010000 with continuous valid:
  - out_data=0x00370000 (55.0), sat=0.
  - out_valid in cycle 11 after start.
  - weight_adr sequence 0..9.
- Only feature index 3 = 0x00020000, others 0, bias 0xFFFF0000 (-1.0) -> out_data=0x00070000 (7.0).
- bias 0x7FFF0000 with the all-1.0 stimulus -> out_data=0x7FFFFFFF, sat=1. Negated case: bias 0x80010000 with features 0xFFFF0000 (-1.0) -> out_data=0x80000000, sat=1.
- feat_valid toggled every other cycle, and out_ready held low for 5 cycles in OUT:
  - result still 0x00370000.
  - out_data and out_valid stable through the stall.
  - done pulses exactly once, on the first out_ready cycle.
  - start pulses during RUN/OUT are ignored.
- rst asserted asynchronously mid-RUN at idx=4:
  - outputs and idx go to 0 immediately.
  - A subsequent full run gives 0x00370000, with no carry-over from the aborted run.
